mips_fetch_queue: RTL

Parametrised instruction-fetch stage for the pipelined MIPS core. It replaces the single IF/ID register with a DEPTH-entry prefetch FIFO, a ready/valid handshake toward decode, and branch-redirect flush. It sits between the instruction memory and the decode stage, and takes the branch redirect (`pc_src`, `add_res`) from the memory stage.

---
 rtl/mips_fetch_queue_if.sv | 31 +++
 rtl/mips_fetch_queue.sv | 114 +++++++++++
 2 files changed

// File: rtl/mips_fetch_queue_if.sv
// Fetch-queue bundle: branch redirect in, instruction-memory port, decode handshake and statistics out.
// The slave modport is the fetch queue itself; the master modport is its environment.
interface mips_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            pc_src;
    logic [XLEN-1:0] add_res;
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic            d_ready;
    logic            d_valid;
    logic [31:0]     d_inst;
    logic [XLEN-1:0] d_pc;
    logic [CW-1:0]   count;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport slave (
        input  pc_src, add_res, imem_rdata, d_ready,
        output imem_addr, d_valid, d_inst, d_pc, count, stall_cnt, flush_cnt
    );

    modport master (
        output pc_src, add_res, imem_rdata, d_ready,
        input  imem_addr, d_valid, d_inst, d_pc, count, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/mips_fetch_queue.sv
// Instruction prefetch FIFO between imem and decode; fetched word visible on d_* one edge after its PC is sampled.
// Fetch stalls (PC holds) only when full with no pop; a redirect flushes everything and refetches from the target.
module mips_fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    mips_fetch_queue_if.slave bus
);
    localparam int            PTR_W = $clog2(DEPTH);
    localparam int            CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           head;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             vld;
    logic             pop;
    logic             push;
    logic             unused_add_res_lsb;

    assign unused_add_res_lsb = ^bus.add_res[1:0];

    always_comb begin
        vld     = (count_q != '0);
        pop     = vld & bus.d_ready;
        // A full queue can still accept the new word when the head leaves this edge.
        push    = !bus.pc_src && ((count_q != FULL) || pop);
        pc_d    = pc_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        stall_d = stall_q;
        flush_d = flush_q;

        if (bus.pc_src) begin
            pc_d    = {bus.add_res[XLEN-1:2], 2'b00};
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d = pc_q + XLEN'(4);
                wr_d = wr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        if (vld && !bus.d_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (bus.pc_src && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            pc_q    <= pc_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {pc_q, bus.imem_rdata};
        end
    end

    assign head          = mem_q[rd_q];
    assign bus.imem_addr = pc_q;
    assign bus.d_valid   = vld;
    assign bus.d_inst    = vld ? head.inst : 32'h0;
    assign bus.d_pc      = vld ? head.pc : '0;
    assign bus.count     = count_q;
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;

    a_count_bound : assert property (@(posedge clk) disable iff (rst) count_q <= FULL);
    a_ptr_diff    : assert property (@(posedge clk) disable iff (rst)
                                     PTR_W'(wr_q - rd_q) == count_q[PTR_W-1:0]);
endmodule
